aes_encipher_ctrl: RTL and testbench



---
 rtl/aes_encipher_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_aes_encipher_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_ctrl.sv
`timescale 1ns/1ps
// aes_encipher_ctrl
//
// Sequencer for the combinational AES encipher round datapath. It holds the
// 128-bit state register and the round counter. Each cycle it presents the
// round index to the key memory and the round type to the round datapath.
// It then captures the datapath result on the clock edge. One block is in
// flight at a time, and a ready/next handshake faces the AES core top.
//
// Optional feature (macro AES_ENCIPHER_CTRL_ABORT_EN):
//   This macro adds the abort input. An asserted abort in INIT, MAIN or FINAL
//   returns the sequencer to IDLE and leaves new_block untouched. Without the
//   macro there is no abort port, and every started block runs to completion.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   next          start pulse, sampled only while ready=1
//   abort         (optional) cancel the operation in flight
//   keylen        0=AES-128, 1=AES-256, latched at start
//   block         plaintext block, latched at start
//   round         round index to key memory (Moore)
//   round_type    0=INIT 1=MAIN 2=FINAL 3=IDLE/no-op (Moore)
//   round_block   current state register, fed to round datapath
//   round_result  combinational round datapath output
//   ready         idle and able to accept next
//   result_valid  new_block holds a completed ciphertext
//   new_block     ciphertext result register
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for next; round=0, round_type=IDLE
// INIT   | initial AddRoundKey with round key 0
// MAIN   | full rounds 1 .. num_rounds-1, round index = round_ctr
// FINAL  | last round (no MixColumns), result captured into new_block

module aes_encipher_ctrl #(
   parameter int AES128_ROUNDS = 10,
   parameter int AES256_ROUNDS = 14
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
`ifdef AES_ENCIPHER_CTRL_ABORT_EN
   input  logic         abort,
`endif
   input  logic         keylen,
   input  logic [127:0] block,
   output logic [3:0]   round,
   output logic [1:0]   round_type,
   output logic [127:0] round_block,
   input  logic [127:0] round_result,
   output logic         ready,
   output logic         result_valid,
   output logic [127:0] new_block
);

   localparam logic [3:0] NR_128 = 4'(AES128_ROUNDS);
   localparam logic [3:0] NR_256 = 4'(AES256_ROUNDS);

   localparam logic [1:0] RT_INIT  = 2'd0;
   localparam logic [1:0] RT_MAIN  = 2'd1;
   localparam logic [1:0] RT_FINAL = 2'd2;
   localparam logic [1:0] RT_IDLE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INIT  = 2'd1,
      ST_MAIN  = 2'd2,
      ST_FINAL = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    round_ctr_q, round_ctr_d;
   logic [127:0]  state_reg_q, state_reg_d;
   logic          keylen_q, keylen_d;
   logic          ready_q, ready_d;
   logic          result_valid_q, result_valid_d;
   logic [127:0]  new_block_q, new_block_d;
   logic [3:0]    num_rounds;
   logic          abort_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         round_ctr_q    <= 4'd0;
         state_reg_q    <= '0;
         keylen_q       <= 1'b0;
         ready_q        <= 1'b1;
         result_valid_q <= 1'b0;
         new_block_q    <= '0;
      end else begin
         state_q        <= state_d;
         round_ctr_q    <= round_ctr_d;
         state_reg_q    <= state_reg_d;
         keylen_q       <= keylen_d;
         ready_q        <= ready_d;
         result_valid_q <= result_valid_d;
         new_block_q    <= new_block_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      round_ctr_d    = round_ctr_q;
      state_reg_d    = state_reg_q;
      keylen_d       = keylen_q;
      ready_d        = ready_q;
      result_valid_d = result_valid_q;
      new_block_d    = new_block_q;
      round          = 4'd0;
      round_type     = RT_IDLE;
      num_rounds     = keylen_q ? NR_256 : NR_128;
`ifdef AES_ENCIPHER_CTRL_ABORT_EN
      abort_req      = abort;
`else
      abort_req      = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            // abort is deliberately not looked at here, so abort+next starts
            if (next) begin
               state_reg_d    = block;
               keylen_d       = keylen;
               round_ctr_d    = 4'd0;
               ready_d        = 1'b0;
               result_valid_d = 1'b0;
               state_d        = ST_INIT;
            end
         end

         ST_INIT: begin
            round_type = RT_INIT;
            if (abort_req) begin
               state_reg_d = '0;
               round_ctr_d = 4'd0;
               ready_d     = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_reg_d = round_result;
               round_ctr_d = 4'd1;
               state_d     = ST_MAIN;
            end
         end

         ST_MAIN: begin
            round      = round_ctr_q;
            round_type = RT_MAIN;
            if (abort_req) begin
               state_reg_d = '0;
               round_ctr_d = 4'd0;
               ready_d     = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_reg_d = round_result;
               round_ctr_d = round_ctr_q + 4'd1;
               if (round_ctr_q == (num_rounds - 4'd1)) begin
                  state_d = ST_FINAL;
               end
            end
         end

         ST_FINAL: begin
            round      = num_rounds;
            round_type = RT_FINAL;
            // abort wins over completion: the result is dropped
            if (abort_req) begin
               state_reg_d = '0;
               round_ctr_d = 4'd0;
               ready_d     = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               new_block_d    = round_result;
               result_valid_d = 1'b1;
               ready_d        = 1'b1;
               round_ctr_d    = 4'd0;
               state_d        = ST_IDLE;
            end
         end

         default: begin
            state_d        = ST_IDLE;
            state_reg_d    = '0;
            round_ctr_d    = 4'd0;
            keylen_d       = 1'b0;
            ready_d        = 1'b1;
            result_valid_d = 1'b0;
            new_block_d    = '0;
         end
      endcase
   end

   assign round_block  = state_reg_q;
   assign ready        = ready_q;
   assign result_valid = result_valid_q;
   assign new_block    = new_block_q;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
`timescale 1ns/1ps
// Testbench for aes_encipher_ctrl. It holds a reference AES round datapath
// and a key memory (schedule expanded by load_key), and it checks the
// FIPS-197 example ciphertexts.

module tb_aes_encipher_ctrl;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk;
   logic         reset_n;
   logic         next;
   logic         abort;
   logic         keylen;
   logic [127:0] block;
   logic [3:0]   round;
   logic [1:0]   round_type;
   logic [127:0] round_block;
   logic [127:0] round_result;
   logic         ready;
   logic         result_valid;
   logic [127:0] new_block;

   int n_checks;
   int n_pass;

   logic [7:0]   sbox [256];
   logic [31:0]  w    [60];
   logic [127:0] rk   [16];

   aes_encipher_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .next         (next),
`ifdef AES_ENCIPHER_CTRL_ABORT_EN
      .abort        (abort),
`endif
      .keylen       (keylen),
      .block        (block),
      .round        (round),
      .round_type   (round_type),
      .round_block  (round_block),
      .round_result (round_result),
      .ready        (ready),
      .result_valid (result_valid),
      .new_block    (new_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference AES pieces ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   task automatic load_key(input logic [255:0] key, input logic kl);
      int nk;
      int nw;
      logic [31:0] t;
      logic [7:0]  rc;
      nk = kl ? 8 : 4;
      nw = kl ? 60 : 44;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r < nw / 4; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // round datapath; key memory read is combinational on round
   always_comb begin
      round_result = round_block;
      case (round_type)
         2'd0:    round_result = round_block ^ rk[round];
         2'd1:    round_result = mix_cols(sub_shift(round_block)) ^ rk[round];
         2'd2:    round_result = sub_shift(round_block) ^ rk[round];
         default: round_result = round_block;
      endcase
   end

   // ---------------- bench utilities ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [127:0] blk, input logic kl,
                         input int exp_busy, input logic [127:0] exp_ct);
      int busy;
      block  = blk;
      keylen = kl;
      next   = 1'b1;
      tick();
      next   = 1'b0;
      busy   = 0;
      while (!ready && busy < 40) begin
         busy++;
         tick();
      end
      check({tag, ".busy"},  128'(busy), 128'(exp_busy));
      check({tag, ".valid"}, 128'(result_valid), 128'd1);
      check({tag, ".ct"},    new_block, exp_ct);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int starts;
      int start0;
      int start1;
      logic prev_ready;
      logic [127:0] prev_ct;

      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      next     = 1'b0;
      abort    = 1'b0;
      keylen   = 1'b0;
      block    = '0;
      build_sbox();
      load_key(KEY128, 1'b0);
      tick();
      tick();

      // reset state
      check("rst.ready",      128'(ready), 128'd1);
      check("rst.valid",      128'(result_valid), 128'd0);
      check("rst.new_block",  new_block, 128'd0);
      check("rst.round",      128'(round), 128'd0);
      check("rst.round_type", 128'(round_type), 128'd3);
      check("rst.state",      round_block, 128'd0);
      reset_n = 1'b1;
      tick();

      // AES-128 known answer
      run_op("aes128", PT, 1'b0, 11, CT128);

      // AES-256 with round/round_type trace
      load_key(KEY256, 1'b1);
      block  = PT;
      keylen = 1'b1;
      next   = 1'b1;
      tick();
      next   = 1'b0;
      for (int k = 0; k < 15; k++) begin
         check($sformatf("aes256.busy%0d", k), 128'(ready), 128'd0);
         check($sformatf("aes256.round%0d", k), 128'(round), 128'(k));
         check($sformatf("aes256.rtype%0d", k), 128'(round_type),
               (k == 0) ? 128'd0 : ((k == 14) ? 128'd2 : 128'd1));
         tick();
      end
      check("aes256.ready", 128'(ready), 128'd1);
      check("aes256.valid", 128'(result_valid), 128'd1);
      check("aes256.ct",    new_block, CT256);
      check("aes256.idle_rtype", 128'(round_type), 128'd3);

      // next held high: back-to-back starts, mid-operation input changes ignored
      load_key(KEY128, 1'b0);
      block      = PT;
      keylen     = 1'b0;
      next       = 1'b1;
      starts     = 0;
      start0     = -1;
      start1     = -1;
      prev_ready = ready;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (prev_ready && !ready) begin
            if (starts == 0) start0 = c;
            else if (starts == 1) start1 = c;
            starts++;
         end
         if (c == 2) begin
            block  = ~PT;
            keylen = 1'b1;
         end
         if (c == 8) begin
            block  = PT;
            keylen = 1'b0;
         end
         if (c == 11) begin
            check("b2b.first_ready", 128'(ready), 128'd1);
            check("b2b.first_ct",    new_block, CT128);
         end
         if (c == 12) begin
            check("b2b.valid_drop", 128'(result_valid), 128'd0);
            check("b2b.ct_hold",    new_block, CT128);
         end
         if (c == 23) begin
            check("b2b.second_valid", 128'(result_valid), 128'd1);
            check("b2b.second_ct",    new_block, CT128);
         end
         prev_ready = ready;
      end
      next = 1'b0;
      tick();
      tick();
      check("b2b.starts", 128'(starts), 128'd2);
      check("b2b.start0", 128'(start0), 128'd0);
      check("b2b.start1", 128'(start1), 128'd12);
      check("b2b.idle",   128'(ready), 128'd1);

      // reset in MAIN round 5
      block  = PT;
      keylen = 1'b0;
      next   = 1'b1;
      tick();
      next   = 1'b0;
      for (int k = 0; k < 20 && round != 4'd5; k++) tick();
      check("rstmid.round", 128'(round), 128'd5);
      reset_n = 1'b0;
      #1;
      check("rstmid.ready", 128'(ready), 128'd1);
      check("rstmid.valid", 128'(result_valid), 128'd0);
      check("rstmid.rtype", 128'(round_type), 128'd3);
      check("rstmid.nb",    new_block, 128'd0);
      tick();
      check("rstmid.held_ready", 128'(ready), 128'd1);
      check("rstmid.held_nb",    new_block, 128'd0);
      reset_n = 1'b1;
      tick();
      run_op("after_rst", PT, 1'b0, 11, CT128);

`ifdef AES_ENCIPHER_CTRL_ABORT_EN
      // abort at MAIN round 7
      prev_ct = new_block;
      block   = ~PT;
      keylen  = 1'b0;
      next    = 1'b1;
      tick();
      next    = 1'b0;
      for (int k = 0; k < 20 && round != 4'd7; k++) tick();
      check("abort.round", 128'(round), 128'd7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort.ready", 128'(ready), 128'd1);
      check("abort.valid", 128'(result_valid), 128'd0);
      check("abort.nb",    new_block, prev_ct);
      check("abort.rtype", 128'(round_type), 128'd3);

      // abort during FINAL beats completion
      next = 1'b1;
      tick();
      next = 1'b0;
      for (int k = 0; k < 20 && round_type != 2'd2; k++) tick();
      check("abortfin.rtype", 128'(round_type), 128'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abortfin.ready", 128'(ready), 128'd1);
      check("abortfin.valid", 128'(result_valid), 128'd0);
      check("abortfin.nb",    new_block, prev_ct);

      // abort together with next in IDLE still starts
      abort = 1'b1;
      run_op("abort_next", PT, 1'b0, 11, CT128);
      abort = 1'b0;
      run_op("after_abort", PT, 1'b0, 11, CT128);
`else
      prev_ct = new_block;
      check("noabort.ct", prev_ct, CT128);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
